// File: rtl/jtdd_scan2x_pkg.sv
// Shared defaults, packed RGB layout and the scanline dimming helper for jtdd_scan2x.
package jtdd_scan2x_pkg;
  localparam int DW_DEF = 12;
  localparam int AW_DEF = 8;
  localparam int R_LSB  = 8;
  localparam int G_LSB  = 4;
  localparam int B_LSB  = 0;

  // 75% brightness per 4-bit component: c - c/4
  function automatic logic [3:0] dim4(input logic [3:0] c);
    return c - (c >> 2);
  endfunction

  function automatic logic [11:0] dim_rgb(input logic [11:0] px);
    return {dim4(px[R_LSB +: 4]), dim4(px[G_LSB +: 4]), dim4(px[B_LSB +: 4])};
  endfunction
endpackage

// File: rtl/jtdd_scan2x_ram.sv
// Ping-pong line store: one write port on the input pixel rate, registered read on the output rate.
module jtdd_scan2x_ram #(
  parameter int DW = 12,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW:0]   waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW:0]   raddr,
  output logic [DW-1:0] q
);
  logic [DW-1:0] mem [0:(1 << (AW + 1)) - 1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) q <= mem[raddr];
  end
endmodule

// File: rtl/jtdd_scan2x.sv
// Line doubler: captures each visible line and replays it twice at pxl2_cen for 31 kHz output.
// Build option: define JTDD_SCAN2X_DIM_EN to dim the second replay of every line to 75%.
module jtdd_scan2x
  import jtdd_scan2x_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int AW       = AW_DEF,
  parameter int HTOTAL   = 384,
  parameter int HS_START = 320,
  parameter int HS_LEN   = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pxl_cen,
  input  logic          pxl2_cen,
  input  logic          LHBL,
  input  logic          LVBL,
  input  logic [DW-1:0] rgb_in,
  output logic [DW-1:0] rgb_out,
  output logic          LHBL_out,
  output logic          LVBL_out,
  output logic          HS_out,
  output logic          VS_out
);
  localparam int RW = $clog2(HTOTAL);
  localparam logic [AW:0] FULL_LEN = {1'b1, {AW{1'b0}}};

  logic [AW-1:0] wr_cnt;
  logic          wr_full, bank, lhbl_l, lvbl_l, vb_fall;
  logic          valid, vb_line, vs_line, half;
  logic [AW:0]   line_len;
  logic [RW-1:0] rd_cnt;
  logic          line_end, wr_en;
  logic [DW-1:0] ram_q, px_p0;
  logic          vis_p0, hs_p0, vs_p0, lvbl_p0;

  assign line_end = pxl_cen & lhbl_l & ~LHBL;
  assign wr_en    = pxl_cen & LHBL & ~wr_full;

  jtdd_scan2x_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr ({bank, wr_cnt}),
    .wdata (rgb_in),
    .re    (pxl2_cen),
    .raddr ({~bank, rd_cnt[AW-1:0]}),
    .q     (ram_q)
  );

  // write side, line-end bookkeeping and read counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_cnt   <= '0;
      wr_full  <= 1'b0;
      bank     <= 1'b0;
      lhbl_l   <= 1'b0;
      lvbl_l   <= 1'b0;
      vb_fall  <= 1'b0;
      valid    <= 1'b0;
      line_len <= '0;
      vb_line  <= 1'b1;
      vs_line  <= 1'b0;
      rd_cnt   <= '0;
      half     <= 1'b0;
    end else begin
      if (pxl_cen) begin
        lhbl_l <= LHBL;
        lvbl_l <= LVBL;
        if (lvbl_l && !LVBL) vb_fall <= 1'b1;
      end
      // the last address is kept once written so later pixels never wrap onto the line start
      if (wr_en) begin
        if (&wr_cnt) wr_full <= 1'b1;
        else         wr_cnt  <= wr_cnt + AW'(1);
      end
      if (line_end) begin
        line_len <= wr_full ? FULL_LEN : {1'b0, wr_cnt};
        wr_cnt   <= '0;
        wr_full  <= 1'b0;
        bank     <= ~bank;
        valid    <= 1'b1;
        vb_line  <= ~LVBL;
        vs_line  <= vb_fall | (lvbl_l & ~LVBL);
        vb_fall  <= 1'b0;
        rd_cnt   <= '0;
        half     <= 1'b0;
      end else if (pxl2_cen) begin
        if (rd_cnt == RW'(HTOTAL - 1)) begin
          rd_cnt  <= '0;
          half    <= ~half;
          vs_line <= 1'b0;
        end else begin
          rd_cnt <= rd_cnt + RW'(1);
        end
      end
    end
  end

  // p0: control sampled alongside the RAM read
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vis_p0  <= 1'b0;
      hs_p0   <= 1'b0;
      vs_p0   <= 1'b0;
      lvbl_p0 <= 1'b0;
    end else if (pxl2_cen) begin
      vis_p0  <= valid & (32'(rd_cnt) < 32'(line_len));
      hs_p0   <= valid & (32'(rd_cnt) >= HS_START) & (32'(rd_cnt) < HS_START + HS_LEN);
      vs_p0   <= vs_line & ~half;
      lvbl_p0 <= ~vb_line;
    end
  end

`ifdef JTDD_SCAN2X_DIM_EN
  logic half_p0;

  always_ff @(posedge clk) begin
    if (!rst_n)        half_p0 <= 1'b0;
    else if (pxl2_cen) half_p0 <= half;
  end

  assign px_p0 = half_p0 ? dim_rgb(ram_q) : ram_q;
`else
  assign px_p0 = ram_q;
`endif

  // p1: output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb_out  <= '0;
      LHBL_out <= 1'b0;
      LVBL_out <= 1'b0;
      HS_out   <= 1'b0;
      VS_out   <= 1'b0;
    end else if (pxl2_cen) begin
      rgb_out  <= vis_p0 ? px_p0 : '0;
      LHBL_out <= vis_p0;
      LVBL_out <= lvbl_p0;
      HS_out   <= hs_p0;
      VS_out   <= vs_p0;
    end
  end
endmodule

// File: tb/tb_jtdd_scan2x.sv
// Self-checking bench for jtdd_scan2x: per-tick expected outputs queued at each line end.
module tb_jtdd_scan2x;
  localparam int HTOTAL = 384;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pxl_cen = 1'b0;
  logic        pxl2_cen = 1'b0;
  logic        LHBL = 1'b0;
  logic        LVBL = 1'b1;
  logic [11:0] rgb_in = 12'h000;
  logic [11:0] rgb_out;
  logic        LHBL_out, LVBL_out, HS_out, VS_out;

  jtdd_scan2x dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pxl_cen  (pxl_cen),
    .pxl2_cen (pxl2_cen),
    .LHBL     (LHBL),
    .LVBL     (LVBL),
    .rgb_in   (rgb_in),
    .rgb_out  (rgb_out),
    .LHBL_out (LHBL_out),
    .LVBL_out (LVBL_out),
    .HS_out   (HS_out),
    .VS_out   (VS_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tick;
    logic [15:0] v;   // {rgb, lhbl, lvbl, hs, vs}
  } exp_t;

  exp_t exp_q[$];
  int   tick_cnt = 0;
  int   last_tick = 0;
  bit   tick_hit = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   cnt_lhbl = 0, cnt_vs = 0, cnt_hs = 0, cnt_lvbl = 0;

  // reference state: the most recently captured line
  logic [11:0] m_pix [256];
  int          m_len = 0;
  bit          m_end = 1'b0;
  bit          m_fell = 1'b0;
  logic        cur_lvbl = 1'b1;

  exp_t        mon_e;
  logic [15:0] mon_act;

`ifdef JTDD_SCAN2X_DIM_EN
  function automatic logic [11:0] dim_px(input logic [11:0] c);
    logic [11:0] r;
    logic [3:0]  n;
    r = 12'h000;
    for (int i = 0; i < 3; i++) begin
      n = c[i*4 +: 4];
      r[i*4 +: 4] = n - (n >> 2);
    end
    return r;
  endfunction
`endif

  always @(posedge clk) begin
    tick_hit = pxl2_cen;
    if (pxl2_cen) begin
      last_tick = tick_cnt;
      tick_cnt++;
    end
  end

  always @(negedge clk) begin
    if (tick_hit) begin
      mon_act = {rgb_out, LHBL_out, LVBL_out, HS_out, VS_out};
      if (LHBL_out) cnt_lhbl++;
      if (VS_out)   cnt_vs++;
      if (HS_out)   cnt_hs++;
      if (LVBL_out) cnt_lvbl++;
      while (exp_q.size() > 0 && exp_q[0].tick < last_tick) begin
        mon_e = exp_q.pop_front();
        n_checks++;
        $display("FAIL sb_skipped tick=%0d expected=%h never compared", mon_e.tick, mon_e.v);
      end
      if (exp_q.size() > 0 && exp_q[0].tick == last_tick) begin
        mon_e = exp_q.pop_front();
        n_checks++;
        if (mon_act !== mon_e.v)
          $display("FAIL sb_out tick=%0d got rgb=%h lhbl/lvbl/hs/vs=%b expected rgb=%h lhbl/lvbl/hs/vs=%b",
                   last_tick, mon_act[15:4], mon_act[3:0], mon_e.v[15:4], mon_e.v[3:0]);
        else
          n_pass++;
      end
    end
  end

  task automatic cyc(input bit c1, input bit c2);
    pxl_cen  = c1;
    pxl2_cen = c2;
    @(negedge clk);
  endtask

  task automatic push_zeros(input int from, input int upto);
    exp_t e;
    for (int t = from; t <= upto; t++) begin
      e.tick = t;
      e.v    = 16'h0000;
      exp_q.push_back(e);
    end
  endtask

  // One input line of HTOTAL pixels, the last npix visible. kind: 0=address, 1=white, 2=random.
  // tog>0 flips LVBL at that pixel; rst_at>=0 pulses rst_n during that pixel.
  task automatic drive_line(input int npix, input int kind, input int tog, input int rst_at);
    logic [11:0] px;
    int          t0;
    int          w;
    exp_t        e;
    t0 = tick_cnt;
    if (m_end) begin
      for (int k = 0; k < 2 * HTOTAL; k++) begin
        int          r;
        bit          h, vis;
        logic [11:0] c;
        r   = k % HTOTAL;
        h   = (k >= HTOTAL);
        vis = (r < m_len);
        c   = vis ? m_pix[r] : 12'h000;
`ifdef JTDD_SCAN2X_DIM_EN
        if (h) c = dim_px(c);
`endif
        e.tick = t0 + 2 + k;
        e.v    = {c, vis, cur_lvbl, (r >= 320 && r < 352), (m_fell && !h)};
        exp_q.push_back(e);
      end
    end else begin
      push_zeros(t0, t0 + 2 * HTOTAL + 1);
    end
    m_fell = 1'b0;
    w = 0;
    for (int p = 0; p < HTOTAL; p++) begin
      if (p == tog) begin
        if (cur_lvbl) m_fell = 1'b1;
        cur_lvbl = ~cur_lvbl;
      end
      LVBL = cur_lvbl;
      LHBL = (p >= HTOTAL - npix);
      case (kind)
        0:       px = 12'(w);
        1:       px = 12'hFFF;
        default: px = 12'($urandom);
      endcase
      rgb_in = px;
      if (LHBL) begin
        if (w < 256) m_pix[w] = px;
        w++;
      end
      cyc(1'b1, 1'b1);
      if (p == rst_at) begin
        rst_n = 1'b0;
        cyc(1'b0, 1'b0);
        rst_n = 1'b1;
        n_checks++;
        if ({rgb_out, LHBL_out, LVBL_out, HS_out, VS_out} !== 16'h0000)
          $display("FAIL mid_reset_outputs got rgb=%h lhbl/lvbl/hs/vs=%b%b%b%b expected all zero",
                   rgb_out, LHBL_out, LVBL_out, HS_out, VS_out);
        else
          n_pass++;
        while (exp_q.size() > 0 && exp_q[$].tick >= tick_cnt) void'(exp_q.pop_back());
        push_zeros(tick_cnt, t0 + 2 * HTOTAL + 1);
        m_fell = 1'b0;
      end else begin
        cyc(1'b0, 1'b0);
      end
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b0);
    end
    m_len = (npix > 256) ? 256 : npix;
    m_end = (npix > 0);
  endtask

  task automatic clear_counts();
    cnt_lhbl = 0;
    cnt_vs   = 0;
    cnt_hs   = 0;
    cnt_lvbl = 0;
  endtask

  task automatic check_cnt(input string name, input int got, input int want);
    n_checks++;
    if (got !== want) $display("FAIL %s got=%0d expected=%0d", name, got, want);
    else n_pass++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({rgb_out, LHBL_out, LVBL_out, HS_out, VS_out} !== 16'h0000)
      $display("FAIL reset_outputs got rgb=%h lhbl/lvbl/hs/vs=%b%b%b%b expected all zero",
               rgb_out, LHBL_out, LVBL_out, HS_out, VS_out);
    else
      n_pass++;
    repeat (4) begin
      cyc(1'b1, 1'b1);
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b0);
    end
    rst_n = 1'b1;
    clear_counts();
    drive_line(256, 0, -1, -1);
    check_cnt("capture_line_lhbl", cnt_lhbl, 0);
    check_cnt("capture_line_hs", cnt_hs, 0);
  endtask

  task automatic test_full_line();
    clear_counts();
    drive_line(100, 2, -1, -1);
    check_cnt("full_line_lhbl", cnt_lhbl, 512);
  endtask

  task automatic test_short_line();
    clear_counts();
    drive_line(300, 0, -1, -1);
    check_cnt("short_line_lhbl", cnt_lhbl, 200);
    check_cnt("short_line_hs", cnt_hs, 64);
  endtask

  task automatic test_long_line();
    clear_counts();
    drive_line(256, 1, -1, -1);
    check_cnt("long_line_lhbl", cnt_lhbl, 512);
  endtask

  task automatic test_dim();
    clear_counts();
    drive_line(50, 2, 200, -1);
    check_cnt("dim_line_lhbl", cnt_lhbl, 512);
  endtask

  task automatic test_vblank();
    clear_counts();
    drive_line(80, 2, -1, -1);
    check_cnt("vblank_vs_first", cnt_vs, 384);
    clear_counts();
    drive_line(60, 2, 100, -1);
    check_cnt("vblank_vs_second", cnt_vs, 0);
    check_cnt("vblank_lvbl_second", cnt_lvbl, 0);
  endtask

  task automatic test_reset_mid();
    drive_line(120, 2, -1, 20);
    clear_counts();
    drive_line(0, 2, -1, -1);
    check_cnt("after_reset_lhbl", cnt_lhbl, 240);
  endtask

  initial begin
    test_reset();
    test_full_line();
    test_short_line();
    test_long_line();
    test_dim();
    test_vblank();
    test_reset_mid();
    while (exp_q.size() > 0 && exp_q[$].tick >= tick_cnt) void'(exp_q.pop_back());
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL sb_leftover got=%0d entries expected=0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
